// File: rtl/cordic_div_ctrl.sv
// cordic_div_ctrl: iterative linear-mode CORDIC divider, quotient = y/x * 64.
// One iteration per cycle, using an external combinational LUT (64>>addr).
// Ports:
//   clk, rst          clock, async active-high reset
//   start, x_in, y_in request a divide (accepted when idle), divisor, dividend
//   lut_addr, lut_val LUT address (iteration index) and the LUT data it returns
//   busy, done        iterating; one-cycle completion pulse
//   quotient          signed result, 6 fractional bits, held until next result
//   div_by_zero       last accepted divisor was zero
module cordic_div_ctrl #(
  parameter int ITER = 7,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic [2:0]   lut_addr,
  input  logic [W-1:0] lut_val,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic         div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [2:0]          i;
  logic signed [W-1:0] x, z, q;
  logic signed [W+1:0] y;       // two guard bits: the residual can reach ~2|x|
  logic signed [W+1:0] xe, sx, y_nxt;
  logic signed [W-1:0] z_nxt;
  logic                same, last, can_start;

  assign xe    = {{2{x[W-1]}}, x};
  assign sx    = xe >>> i;
  // y == 0 counts as non-negative, so only the sign bits are compared
  assign same  = (y[W+1] == x[W-1]);
  assign y_nxt = same ? y - sx : y + sx;
  assign z_nxt = same ? z + $signed(lut_val) : z - $signed(lut_val);
  assign last  = (i == 3'(ITER-1));

  // The DONE cycle also serves as the first idle cycle: a start seen there is
  // taken at the edge that leaves DONE, which gives back-to-back divides an
  // 8-cycle cadence. The result is already registered, so nothing in flight
  // is disturbed.
  assign can_start = (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      i           <= '0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      q           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_ITER: begin
          y <= y_nxt;
          z <= z_nxt;
          if (last) begin
            q     <= z_nxt;
            i     <= '0;
            state <= S_DONE;
          end else begin
            i <= i + 3'd1;
          end
        end
        S_IDLE, S_DONE: begin
          if (start && can_start) begin
            if (x_in == '0) begin
              div_by_zero <= 1'b1;
              q           <= '0;
              state       <= S_DONE;
            end else begin
              x           <= x_in;
              y           <= {{2{y_in[W-1]}}, y_in};
              z           <= '0;
              i           <= '0;
              div_by_zero <= 1'b0;
              state       <= S_ITER;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state == S_ITER);
  assign done     = (state == S_DONE);
  assign lut_addr = busy ? i : 3'd0;
  assign quotient = q;

endmodule

// File: tb/tb_cordic_div_ctrl.sv
module tb_cordic_div_ctrl;
  localparam int W    = 16;
  localparam int ITER = 7;

  logic         clk = 0, rst = 0, start = 0;
  logic [W-1:0] x_in = '0, y_in = '0, lut_val, quotient;
  logic [2:0]   lut_addr;
  logic         busy, done, dbz;
  int           nchk = 0, nerr = 0;
  bit           chk_en = 0;

  cordic_div_ctrl #(.ITER(ITER), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .lut_addr(lut_addr), .lut_val(lut_val), .busy(busy), .done(done),
    .quotient(quotient), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;
  assign lut_val = W'(64) >> lut_addr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // quotient of y/x*64 by the CORDIC sign rule, in plain integers
  function automatic int model_q(input int x, input int y);
    int yy, z, sx;
    yy = y; z = 0;
    for (int k = 0; k < ITER; k++) begin
      sx = x >>> k;
      if ((yy < 0) == (x < 0)) begin yy -= sx; z += (64 >> k); end
      else                     begin yy += sx; z -= (64 >> k); end
    end
    return z;
  endfunction

  // cycle model: age 0 idle, 1..7 iterating (lut addr age-1), 8 done
  int          age = 0;
  logic [15:0] eq = '0, pend = '0;
  bit          edbz = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0; eq = '0; edbz = 0;
    end else if ((age == 0 || age == 8) && start) begin
      if (x_in == '0) begin age = 8; eq = '0; edbz = 1; end
      else begin
        age  = 1; edbz = 0;
        pend = 16'(model_q(int'($signed(x_in)), int'($signed(y_in))));
      end
    end else if (age >= 1 && age <= 6) age++;
    else if (age == 7) begin age = 8; eq = pend; end
    else if (age == 8) age = 0;
  end

  always @(negedge clk) if (chk_en) begin
    check("busy", busy, (age >= 1 && age <= 7));
    check("done", done, (age == 8));
    check("lut_addr", lut_addr, (age >= 1 && age <= 7) ? age - 1 : 0);
    check("quotient", quotient, eq);
    check("div_by_zero", dbz, edbz);
  end

  task automatic run_div(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] expq, input bit expdbz, input int lat);
    int n; bit got;
    @(posedge clk); #2 start = 1; x_in = x; y_in = y;
    @(posedge clk); #2 start = 0;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (n < lat) begin
        check({nm, "_busy"}, busy, 1);
        check({nm, "_lut"}, lut_addr, n - 1);
      end
      if (lat == 1) check({nm, "_busy0"}, busy, 0);
      if (done) got = 1;
    end
    check({nm, "_gotdone"}, got, 1);
    check({nm, "_latency"}, n, lat);
    check({nm, "_q"}, quotient, expq);
    check({nm, "_dbz"}, dbz, expdbz);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] hq [3];
    int nd;
    hq[0] = 16'd33; hq[1] = 16'd127; hq[2] = 16'd127;

    #1 rst = 1;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_lut", lut_addr, 0);
    check("rst_dbz", dbz, 0);
    @(posedge clk); #2 rst = 0;

    // pin the model itself
    check("model_nominal", model_q(64, 32), 33);
    check("model_mixed", model_q(100, -100), -63);
    check("model_satp", model_q(1, 1000), 127);
    check("model_satn", model_q(1, -1000), -127);

    run_div("nominal", 16'd64, 16'd32, 16'd33, 0, 8);
    run_div("mixed", 16'd100, -16'sd100, -16'sd63, 0, 8);
    run_div("sat_pos", 16'd1, 16'd1000, 16'd127, 0, 8);
    run_div("sat_neg", 16'd1, -16'sd1000, -16'sd127, 0, 8);
    run_div("negx", -16'sd50, 16'd30, 16'(model_q(-50, 30)), 0, 8);
    run_div("dbz", 16'd0, 16'd5, 16'd0, 1, 1);
    run_div("after_dbz", 16'd64, 16'd32, 16'd33, 0, 8);

    // start held through three operations; operands change mid-flight
    @(posedge clk); #2 start = 1; x_in = 16'd64; y_in = 16'd32;
    @(posedge clk); #2;
    nd = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 3) begin x_in = 16'd1; y_in = 16'd1000; end
      if (done) begin
        if (nd < 3) begin
          check("held_done_cycle", n, 8 * (nd + 1));
          check("held_q", quotient, hq[nd]);
        end
        nd++;
      end
    end
    start = 0;
    check("held_done_count", nd, 3);
    repeat (3) @(posedge clk);

    // reset in the middle of iteration 3
    @(posedge clk); #2 start = 1; x_in = 16'd100; y_in = -16'sd100;
    @(posedge clk); #2 start = 0;
    repeat (4) @(negedge clk);
    check("mid_lut_before", lut_addr, 3);
    #2 rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_lut", lut_addr, 0);
    @(posedge clk); #2 rst = 0;
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("mid_no_done", nd, 0);
    run_div("post_rst", 16'd64, 16'd32, 16'd33, 0, 8);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
